color_box_tracker: RTL

- Sits directly downstream of the VGA filter stage and consumes its outgoing VGA stream.
- Classifies each active pixel against programmable colour thresholds.
- Accumulates the bounding box of matching pixels over each frame and publishes it at frame end.
- Draws the published box outline onto the next frame's stream before it reaches the VGA DAC.

---
 rtl/color_box_tracker.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/color_box_tracker.sv
`default_nettype none
// ============================================================================
// Module   : color_box_tracker
// Purpose  : Tracks the bounding box of threshold-matched pixels per frame and
//            overlays the previous frame's box on the VGA stream.
//            Optional macro MATCH_HILITE_EN paints matching pixels white.
// Revision : 1.0 - initial release
// ============================================================================
module color_box_tracker #(
    parameter int          WIDTH      = 640,
    parameter int          HEIGHT     = 480,
    parameter int          MIN_PIXELS = 64,
    parameter logic [23:0] BOX_RGB    = 24'h00FF00
) (
    input  logic       VGA_CLK,
    input  logic       reset,
    input  logic [7:0] iVGA_R,
    input  logic [7:0] iVGA_G,
    input  logic [7:0] iVGA_B,
    input  logic       iVGA_HS,
    input  logic       iVGA_VS,
    input  logic       iVGA_SYNC_N,
    input  logic       iVGA_BLANK_N,
    output logic [7:0] oVGA_R,
    output logic [7:0] oVGA_G,
    output logic [7:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_SYNC_N,
    output logic       oVGA_BLANK_N,
    input  logic [7:0] R_MIN,
    input  logic [7:0] G_MAX,
    input  logic [7:0] B_MAX,
    output logic [9:0] box_x_min,
    output logic [9:0] box_x_max,
    output logic [9:0] box_y_min,
    output logic [9:0] box_y_max,
    output logic       box_valid,
    output logic [9:0] LEDR
);

    localparam logic [9:0]  c_x_last     = 10'(WIDTH - 1);
    localparam logic [9:0]  c_y_last     = 10'(HEIGHT - 1);
    localparam logic [18:0] c_min_pixels = 19'(MIN_PIXELS);

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        ACCUM     = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        prev_vs_q, prev_blank_q;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [9:0]  acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [18:0] count_q, count_d;
    logic [9:0]  box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
    logic [9:0]  box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
    logic        box_valid_q, box_valid_d;
    logic [9:0]  ledr_q, ledr_d;
    logic [23:0] rgb_q, rgb_d;
    logic [3:0]  sync_q;

    logic match, vs_fall, blank_fall, pub_valid;
    logic in_x, in_y, on_outline;

    assign match      = iVGA_BLANK_N & (iVGA_R >= R_MIN) & (iVGA_G <= G_MAX) & (iVGA_B <= B_MAX);
    assign vs_fall    = prev_vs_q & ~iVGA_VS;
    assign blank_fall = prev_blank_q & ~iVGA_BLANK_N;
    assign pub_valid  = (count_q >= c_min_pixels);

    // Position counters; x saturates so over-long lines stay on the last column
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!iVGA_VS) begin
            x_d = '0;
            y_d = '0;
        end else if (blank_fall) begin
            x_d = '0;
            y_d = (y_q >= c_y_last) ? c_y_last : y_q + 10'd1;
        end else if (iVGA_BLANK_N) begin
            x_d = (x_q >= c_x_last) ? c_x_last : x_q + 10'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_xmin_d  = acc_xmin_q;
        acc_xmax_d  = acc_xmax_q;
        acc_ymin_d  = acc_ymin_q;
        acc_ymax_d  = acc_ymax_q;
        count_d     = count_q;
        box_x_min_d = box_x_min_q;
        box_x_max_d = box_x_max_q;
        box_y_min_d = box_y_min_q;
        box_y_max_d = box_y_max_q;
        box_valid_d = box_valid_q;
        ledr_d      = ledr_q;
        case (state_q)
            WAIT_SYNC: begin
                if (vs_fall) begin
                    acc_xmin_d = 10'h3FF;
                    acc_ymin_d = 10'h3FF;
                    acc_xmax_d = '0;
                    acc_ymax_d = '0;
                    count_d    = '0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                // Publish takes priority over a coincident match
                if (vs_fall) begin
                    box_valid_d = pub_valid;
                    ledr_d      = {pub_valid, count_q[18:10]};
                    if (pub_valid) begin
                        box_x_min_d = acc_xmin_q;
                        box_x_max_d = acc_xmax_q;
                        box_y_min_d = acc_ymin_q;
                        box_y_max_d = acc_ymax_q;
                    end
                    acc_xmin_d = 10'h3FF;
                    acc_ymin_d = 10'h3FF;
                    acc_xmax_d = '0;
                    acc_ymax_d = '0;
                    count_d    = '0;
                end else if (match) begin
                    if (x_q < acc_xmin_q) acc_xmin_d = x_q;
                    if (x_q > acc_xmax_q) acc_xmax_d = x_q;
                    if (y_q < acc_ymin_q) acc_ymin_d = y_q;
                    if (y_q > acc_ymax_q) acc_ymax_d = y_q;
                    if (count_q != '1) count_d = count_q + 19'd1;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    assign in_x = (x_q >= box_x_min_q) & (x_q <= box_x_max_q);
    assign in_y = (y_q >= box_y_min_q) & (y_q <= box_y_max_q);
    assign on_outline = box_valid_q & iVGA_BLANK_N &
                        ((((x_q == box_x_min_q) | (x_q == box_x_max_q)) & in_y) |
                         (((y_q == box_y_min_q) | (y_q == box_y_max_q)) & in_x));

    always_comb begin
        rgb_d = {iVGA_R, iVGA_G, iVGA_B};
        if (!iVGA_BLANK_N) begin
            rgb_d = '0;
        end else if (on_outline) begin
            rgb_d = BOX_RGB;
        end
`ifdef MATCH_HILITE_EN
        else if (match) begin
            rgb_d = 24'hFFFFFF;
        end
`endif
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state_q      <= WAIT_SYNC;
            prev_vs_q    <= 1'b0;
            prev_blank_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            acc_xmin_q   <= 10'h3FF;
            acc_ymin_q   <= 10'h3FF;
            acc_xmax_q   <= '0;
            acc_ymax_q   <= '0;
            count_q      <= '0;
            box_x_min_q  <= '0;
            box_x_max_q  <= '0;
            box_y_min_q  <= '0;
            box_y_max_q  <= '0;
            box_valid_q  <= 1'b0;
            ledr_q       <= '0;
            rgb_q        <= '0;
            sync_q       <= '0;
        end else begin
            state_q      <= state_d;
            prev_vs_q    <= iVGA_VS;
            prev_blank_q <= iVGA_BLANK_N;
            x_q          <= x_d;
            y_q          <= y_d;
            acc_xmin_q   <= acc_xmin_d;
            acc_ymin_q   <= acc_ymin_d;
            acc_xmax_q   <= acc_xmax_d;
            acc_ymax_q   <= acc_ymax_d;
            count_q      <= count_d;
            box_x_min_q  <= box_x_min_d;
            box_x_max_q  <= box_x_max_d;
            box_y_min_q  <= box_y_min_d;
            box_y_max_q  <= box_y_max_d;
            box_valid_q  <= box_valid_d;
            ledr_q       <= ledr_d;
            rgb_q        <= rgb_d;
            sync_q       <= {iVGA_HS, iVGA_VS, iVGA_SYNC_N, iVGA_BLANK_N};
        end
    end

    assign {oVGA_R, oVGA_G, oVGA_B} = rgb_q;
    assign {oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N} = sync_q;
    assign box_x_min = box_x_min_q;
    assign box_x_max = box_x_max_q;
    assign box_y_min = box_y_min_q;
    assign box_y_max = box_y_max_q;
    assign box_valid = box_valid_q;
    assign LEDR      = ledr_q;

endmodule
`default_nettype wire
